// File: rtl/bank_group_drainer.sv
// Per-bank-group drain engine: answers the group arbiter's req/start/done
// handshake and issues up to MAX_BURSTS round-robin bank requests per grant.
module bank_group_drainer #(
    parameter int NUM_BANKS  = 4,
    parameter int MAX_BURSTS = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [NUM_BANKS-1:0]            bank_valid,
    output logic                            req,
    output logic                            done,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(NUM_BANKS)-1:0]    out_bank,
    output logic [NUM_BANKS-1:0]            bank_pop,
    output logic [$clog2(MAX_BURSTS+1)-1:0] issued_cnt
);

    localparam int BW = $clog2(NUM_BANKS);
    localparam int CW = $clog2(MAX_BURSTS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   issued_cnt_q, issued_cnt_d;

    logic            any_valid_s;
    logic            accept_s;
    logic            last_beat_s;
    logic            found_s;
    logic [BW-1:0]   pick_s;
    logic [BW-1:0]   idx_s;

    assign any_valid_s = |bank_valid;
    assign accept_s    = out_valid & out_ready;
    assign last_beat_s = (issued_cnt_q + CW'(1)) == CW'(MAX_BURSTS);

    // Round-robin search: first valid bank at or after rr_ptr, wrapping.
    always_comb begin
        pick_s  = rr_ptr_q;
        found_s = 1'b0;
        idx_s   = rr_ptr_q;
        for (int i = 0; i < NUM_BANKS; i++) begin
            idx_s = rr_ptr_q + BW'(i);
            if (!found_s && bank_valid[idx_s]) begin
                pick_s  = idx_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= {BW{1'b0}};
            issued_cnt_q <= {CW{1'b0}};
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            issued_cnt_q <= issued_cnt_d;
        end
    end

    // Next-state logic; losing the grant takes priority over every other exit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start && any_valid_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end else if (accept_s && last_beat_s) begin
                    state_d = ST_DONE;
                end else if (!any_valid_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Beat counter and round-robin pointer; the pointer moves only on accept,
    // which keeps out_bank stable while a beat is stalled.
    always_comb begin
        issued_cnt_d = issued_cnt_q;
        rr_ptr_d     = rr_ptr_q;
        if ((state_q == ST_IDLE) && start && any_valid_s) begin
            issued_cnt_d = {CW{1'b0}};
        end else if (accept_s) begin
            issued_cnt_d = issued_cnt_q + CW'(1);
            rr_ptr_d     = pick_s + BW'(1);
        end else begin
            issued_cnt_d = issued_cnt_q;
        end
    end

    // Output decode from the current state.
    always_comb begin
        req       = any_valid_s;
        done      = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req = any_valid_s;
            end
            ST_ISSUE: begin
                req       = 1'b1;
                out_valid = any_valid_s;
            end
            ST_DONE: begin
                req  = any_valid_s;
                done = 1'b1;
            end
            default: begin
                req = any_valid_s;
            end
        endcase
    end

    // One-hot dequeue of the accepted bank.
    always_comb begin
        bank_pop = {NUM_BANKS{1'b0}};
        if (accept_s) begin
            bank_pop[pick_s] = 1'b1;
        end else begin
            bank_pop = {NUM_BANKS{1'b0}};
        end
    end

    assign out_bank   = pick_s;
    assign issued_cnt = issued_cnt_q;

endmodule

// File: tb/tb_bank_group_drainer.sv
// Self-checking bench for bank_group_drainer: directed scenarios plus random
// traffic, all compared against a queue-count reference model.
module tb_bank_group_drainer;

    localparam int NB = 4;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NB-1:0] bank_valid;
    logic          req;
    logic          done;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_bank;
    logic [NB-1:0] bank_pop;
    logic [2:0]    issued_cnt;

    always #5 clk = ~clk;

    bank_group_drainer #(.NUM_BANKS(NB), .MAX_BURSTS(MB)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bank_valid (bank_valid),
        .req        (req),
        .done       (done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bank   (out_bank),
        .bank_pop   (bank_pop),
        .issued_cnt (issued_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: entry counts per bank, grant phase, pointer, beat count.
    int cnt[NB];
    int m_phase;   // 0 waiting for grant, 1 granted/issuing, 2 ending grant
    int m_rr;
    int m_issued;

    int          pop_log[$];
    logic [31:0] pop_hist;
    logic [31:0] done_hist;
    int          step_no;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_any();
        bit a = 1'b0;
        for (int i = 0; i < NB; i++) if (cnt[i] > 0) a = 1'b1;
        return a;
    endfunction

    function automatic int m_pick();
        for (int k = 0; k < NB; k++) begin
            if (cnt[(m_rr + k) % NB] > 0) return (m_rr + k) % NB;
        end
        return m_rr;
    endfunction

    task automatic drive_valid();
        for (int i = 0; i < NB; i++) bank_valid[i] = (cnt[i] > 0);
    endtask

    // One clock cycle: drive at negedge, check mid-cycle, advance model at posedge.
    task automatic step(input bit s, input bit r);
        bit            anyv;
        bit            ov;
        bit            acc;
        int            pk;
        logic [NB-1:0] epop;
        start     = s;
        out_ready = r;
        drive_valid();
        #1;
        anyv = m_any();
        pk   = m_pick();
        ov   = (m_phase == 1) && anyv;
        acc  = ov && r;
        epop = acc ? (NB'(1) << pk) : '0;
        check("req", req, (m_phase == 1) ? 32'd1 : 32'(anyv));
        check("out_valid", out_valid, 32'(ov));
        if (ov) check("out_bank", out_bank, pk);
        check("bank_pop", bank_pop, epop);
        check("done", done, (m_phase == 2) ? 32'd1 : 32'd0);
        check("issued_cnt", issued_cnt, m_issued);
        if (|bank_pop) pop_log.push_back(int'(out_bank));
        if (step_no < 32) begin
            if (done) done_hist[step_no] = 1'b1;
            if (|bank_pop) pop_hist[step_no] = 1'b1;
        end
        @(posedge clk);
        if (m_phase == 0) begin
            if (s && anyv) begin
                m_phase  = 1;
                m_issued = 0;
            end
        end else if (m_phase == 1) begin
            if (acc) begin
                m_issued++;
                cnt[pk]--;
                m_rr = (pk + 1) % NB;
            end
            if (!s) m_phase = 0;
            else if (acc && m_issued == MB) m_phase = 2;
            else if (!anyv) m_phase = 2;
        end else begin
            m_phase = 0;
        end
        step_no++;
        @(negedge clk);
    endtask

    task automatic clear_hist();
        step_no   = 0;
        pop_hist  = '0;
        done_hist = '0;
        pop_log.delete();
    endtask

    int exp_rr[6] = '{0, 2, 3, 0, 2, 3};

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < NB; i++) cnt[i] = 0;
        m_phase = 0; m_rr = 0; m_issued = 0;
        clear_hist();
        drive_valid();
        #2;
        check("rst_req", req, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_pop", bank_pop, 0);
        check("rst_issued", issued_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single bank, 6 entries, grant held: 4 beats, done, re-grant, 2 beats, empty exit.
        cnt[0] = 6;
        clear_hist();
        repeat (11) step(1'b1, 1'b1);
        check("sb_pop_cycles", pop_hist, 32'h0000_019E);
        check("sb_done_cycles", done_hist, 32'h0000_0420);
        step(1'b0, 1'b0);

        // Reset mid-issue with a beat pending, then pointer must restart at 0.
        cnt[0] = 1;
        cnt[3] = 1;
        step(1'b1, 1'b0);
        start = 1'b1; out_ready = 1'b0; drive_valid();
        #1;
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_bank", out_bank, 3);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_pop", bank_pop, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_issued", issued_cnt, 0);
        check("mid_rst_req", req, 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_phase = 0; m_rr = 0; m_issued = 0;
        step(1'b1, 1'b0);
        start = 1'b1; out_ready = 1'b0; drive_valid();
        #1;
        check("post_rst_bank", out_bank, 0);
        step(1'b0, 1'b0);

        // Round-robin over banks 0, 2, 3.
        cnt[0] = 2; cnt[2] = 2; cnt[3] = 2;
        clear_hist();
        repeat (13) step(1'b1, 1'b1);
        check("rr_count", pop_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < pop_log.size()) check("rr_order", pop_log[i], exp_rr[i]);
            else check("rr_order_missing", 32'hFFFF_FFFF, exp_rr[i]);
        end

        // Backpressure for 3 cycles mid-grant.
        cnt[1] = 3;
        clear_hist();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        check("bp_frozen_pops", pop_log.size(), 1);
        check("bp_frozen_issued", issued_cnt, 1);
        check("bp_bank_held", out_bank, 1);
        step(1'b1, 1'b1);
        check("bp_resume_pops", pop_log.size(), 2);
        step(1'b0, 1'b0);

        // Abort after 2 accepts.
        cnt[2] = 4;
        clear_hist();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("abort_no_done", done_hist, 0);
        check("abort_pops", pop_log.size(), 2);
        start = 1'b0; drive_valid();
        #1;
        check("abort_req", req, 1);
        check("abort_idle", out_valid, 0);

        // Grant lost in the same cycle as the final accept.
        cnt[0] = 5;
        clear_hist();
        step(1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check("simul_issued", issued_cnt, 4);
        repeat (2) step(1'b0, 1'b0);
        check("simul_no_done", done_hist, 0);
        check("simul_pops", pop_log.size(), 4);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                int b;
                b = $urandom_range(0, NB - 1);
                if (cnt[b] < 6) cnt[b] += $urandom_range(1, 3);
            end
            step($urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bank_group_drainer.md
# bank_group_drainer

Per-bank-group drain engine; the responder side of the group arbiter's Req/Start/Done handshake. It raises `req` while any bank in its group holds a pending scheduled request. While granted by `start`, it issues up to `MAX_BURSTS` requests, one per handshake beat, selecting banks round-robin. It then pulses `done` so the arbiter can move to the next group. One instance sits between each bank group's per-bank schedulers and the arbiter/command datapath mux.

## Interface

Parameters:
- `NUM_BANKS`, 4: banks per group; power of two, ≥2.
- `MAX_BURSTS`, 4: maximum accepted requests per grant; ≥1.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  grant level from the arbiter; held high while this group is selected.
- `bank_valid`  in  NUM_BANKS  bit i high when bank i's scheduler has a head entry. Bit i deasserts only after the cycle in which `bank_pop[i]` is high.
- `req`  out  1  request to the arbiter.
- `done`  out  1  one-cycle pulse ending a grant.
- `out_valid`  out  1  request beat valid toward the command path.
- `out_ready`  in  1  command path accepts the beat.
- `out_bank`  out  $clog2(NUM_BANKS)  bank index of the current beat; selects the scheduler data mux.
- `bank_pop`  out  NUM_BANKS  one-hot; dequeues the head of the accepted bank.
- `issued_cnt`  out  $clog2(MAX_BURSTS+1)  number of beats accepted in the current grant.

## Operation

- States: IDLE, ISSUE, DONE.
- IDLE:
  - `req` = OR(`bank_valid`).
  - `out_valid` = 0.
  - If `start` && OR(`bank_valid`): go to ISSUE and clear `issued_cnt` to 0.
- ISSUE:
  - `req` = 1.
  - `out_valid` = OR(`bank_valid`).
  - `out_bank` = the first set `bank_valid` index at or after `rr_ptr`, searching upward and wrapping modulo NUM_BANKS.
- Accept occurs when `out_valid` && `out_ready`. On accept:
  - `bank_pop[out_bank]` = 1 in the same cycle.
  - `issued_cnt` increments.
  - `rr_ptr` ← (`out_bank`+1) mod NUM_BANKS.
- `rr_ptr` persists across grants and resets to 0.
- ISSUE exits, evaluated in priority order:
  1. `start` = 0 → IDLE, with no `done`. An accept in that same cycle still completes (pop and count).
  2. An accept makes `issued_cnt` reach MAX_BURSTS → DONE.
  3. OR(`bank_valid`) = 0 → DONE.
  4. Otherwise, stay in ISSUE.
- DONE:
  - `done` = 1 and `out_valid` = 0.
  - `req` = OR(`bank_valid`).
  - Unconditionally go to IDLE next cycle.
- Handshake rule: once `out_valid` is high, `out_bank` is stable until accept. This holds because `bank_valid` bits drop only after a pop and `rr_ptr` moves only on accept.
- Re-grant: if `start` is still high in IDLE after DONE and banks remain valid, a new grant begins. This covers the case where the arbiter keeps the same group because no other group requests.

## Timing

- Reset (async assert) forces:
  - state IDLE, `rr_ptr` 0, `issued_cnt` 0;
  - `done` 0, `out_valid` 0, `bank_pop` 0.
- `req` is combinational and equals OR(`bank_valid`) while in IDLE, including during reset.
- Latency:
  - `start` sampled high in IDLE at cycle t → `out_valid` high at t+1.
  - Final accept at cycle k → `done` high at k+1 → IDLE at k+2 → earliest new ISSUE at k+3.
- Arithmetic: `issued_cnt` never exceeds MAX_BURSTS; no wrap.
- `rr_ptr` arithmetic is modulo NUM_BANKS.
- `bank_pop` is never high when `out_ready` = 0 or outside ISSUE.
- `done` is never high on two consecutive cycles.
- `done` and `out_valid` are never high together.

## Test plan

- Reset: assert `rst` mid-ISSUE with `out_valid`=1.
  - `out_valid`, `bank_pop`, `done` and `issued_cnt` go to 0 immediately.
  - After release, `rr_ptr`=0.
- Single bank: bank 0 holds 6 entries, MAX_BURSTS=4, `out_ready`=1, `start` held high from t.
  - Pops at t+1..t+4 and `done` at t+5.
  - Re-grant ISSUE at t+7, pops at t+7 and t+8, empty exit, `done` at t+10.
- Round-robin: banks 0, 2, 3 valid with 2 entries each.
  - Accept order is 0, 2, 3, 0, then `done`.
  - Next grant starts at bank 2.
- Backpressure: `out_ready`=0 for 3 cycles mid-grant.
  - `out_valid` stays 1, `out_bank` is unchanged, `bank_pop`=0 and `issued_cnt` is frozen.
  - Accept occurs on the cycle `out_ready` rises.
- Abort: `start` falls after 2 accepts.
  - No `done`; state returns to IDLE.
  - `req`=1 while entries remain.
- Simultaneous events: `start` low in the same cycle as the MAX_BURSTS-th accept.
  - The pop completes, IDLE is entered and no `done` is issued.
